reg_bank_arbiter: RTL
=====================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter REGCOUNT, default 20: number of 8-bit registers in the bank.
REQ-002 Parameter SAT_MAX, default 255: saturation value of the contention counter.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 a_req  in  1  requester A (serial-bus slave) access request.
REQ-006 a_we  in  1  A write enable (1 write, 0 read).
REQ-007 a_addr  in  5  A register index.
REQ-008 a_wdata  in  8  A write data.
REQ-009 a_gnt  out  1  A grant, one-cycle pulse.
REQ-010 a_rvalid  out  1  A read data valid, one-cycle pulse.
REQ-011 a_rdata  out  8  A read data.
REQ-012 b_req, b_we, b_addr[4:0], b_wdata[7:0], b_gnt, b_rvalid, b_rdata[7:0]: requester B (parallel-load port), same directions and meanings as A.
REQ-013 addr_err  out  1  one-cycle pulse: serviced access had index >= REGCOUNT.
REQ-014 contention_cnt  out  8  count of cycles where both requests were granted-eligible simultaneously.
REQ-015 registers_packed  out  8*REGCOUNT  bank contents; register i on bits [8i+7:8i].

Function
REQ-016 FSM states IDLE, SERV_A, SERV_B; one access serviced per grant.
REQ-017 IDLE, only a_req -> SERV_A; only b_req -> SERV_B; neither -> IDLE.
REQ-018 IDLE, both requests -> grant the requester not serviced last (round-robin pointer); contention_cnt increments by 1, saturating at SAT_MAX.
REQ-019 a_gnt high exactly while in SERV_A; b_gnt high exactly while in SERV_B; never both.
REQ-020 SERV_x always returns to IDLE at the next edge; maximum throughput one access per 2 cycles.
REQ-021 Address, we and wdata of the granted requester sampled at the edge leaving SERV_x; requester holds them stable from req assertion through its gnt cycle.
REQ-022 Write: register[addr] <= wdata at the edge leaving SERV_x; visible on registers_packed the following cycle.
REQ-023 Read: x_rdata = register[addr], x_rvalid high for the single cycle after SERV_x; x_rdata holds its value until the next read by that requester.
REQ-024 Write produces no rvalid.
REQ-025 addr >= REGCOUNT: write discarded, read returns 0x00 with rvalid, addr_err pulses in the same cycle as rvalid would.
REQ-026 Round-robin pointer updates to the serviced requester on leaving SERV_x.
REQ-027 A request still asserted during its gnt cycle is a new request evaluated in the following IDLE cycle.
REQ-028 Request deasserted before grant is dropped; no access occurs.

Reset
REQ-029 On reset: state IDLE; pointer = B (A wins the first contention); all registers 0x00; a_gnt, b_gnt, a_rvalid, b_rvalid, addr_err = 0; a_rdata, b_rdata = 0x00; contention_cnt = 0.
REQ-030 Reset during SERV_x aborts the access: no write, no rvalid after release.
REQ-031 First possible grant is the cycle after the first edge following reset release with a request present.

Verification
REQ-032 A writes 0x5A to index 3 alone -> a_gnt one cycle; registers_packed[31:24] = 0x5A next cycle; no a_rvalid.
REQ-033 B reads index 3 after REQ-032 -> b_gnt, then b_rvalid with b_rdata = 0x5A.
REQ-034 A and B request in the same cycle after reset, both held -> grants A, B, A, B on alternating cycles; contention_cnt increments on each contended IDLE.
REQ-035 A writes 0xFF to index 20 -> addr_err pulse; registers_packed unchanged. A reads index 25 -> a_rdata = 0x00, a_rvalid and addr_err pulse.
REQ-036 Reset asserted mid-SERV_B write of 0x11 to index 0 -> register 0 remains 0x00; all outputs at reset values.
REQ-037 300 contended cycles -> contention_cnt holds at 255.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two requesters (serial-bus slave A, parallel-load B).
// A round-robin arbiter grants one access per grant cycle and counts contention.
module reg_bank_arbiter #(
  parameter int REGCOUNT = 20,
  parameter int SAT_MAX  = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [4:0]            a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [4:0]            b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [7:0]            b_rdata,
  output logic                  addr_err,
  output logic [7:0]            contention_cnt,
  output logic [8*REGCOUNT-1:0] registers_packed
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate pending requests
  // SERV_A | A granted; its access completes at the edge leaving this state
  // SERV_B | B granted; its access completes at the edge leaving this state
  typedef enum logic [1:0] {IDLE, SERV_A, SERV_B} state_t;

  localparam logic [5:0] REGCOUNT_L = 6'(REGCOUNT);
  localparam logic [7:0] SAT_MAX_L  = 8'(SAT_MAX);

  state_t     state_q, state_d;
  logic       last_b_q, last_b_d;   // 1: B serviced last, so A wins the next tie
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] regs_q [REGCOUNT];
  logic [7:0] regs_d [REGCOUNT];
  logic [7:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic       a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic       addr_err_q, addr_err_d;

  logic       sel_b, sel_we, addr_ok;
  logic [4:0] sel_addr;
  logic [7:0] sel_wdata, rd_val;

  // Next-state, arbitration and access completion for the granted requester
  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    cnt_d      = cnt_q;
    regs_d     = regs_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    addr_err_d = 1'b0;

    sel_b     = (state_q == SERV_B);
    sel_we    = sel_b ? b_we    : a_we;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    addr_ok   = ({1'b0, sel_addr} < REGCOUNT_L);
    rd_val    = addr_ok ? regs_q[sel_addr] : 8'h00;

    case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          state_d = last_b_q ? SERV_A : SERV_B;
          if (cnt_q < SAT_MAX_L) cnt_d = cnt_q + 8'd1;
        end else if (a_req) begin
          state_d = SERV_A;
        end else if (b_req) begin
          state_d = SERV_B;
        end
      end
      SERV_A, SERV_B: begin
        state_d    = IDLE;
        last_b_d   = sel_b;
        addr_err_d = !addr_ok;
        if (sel_we) begin
          if (addr_ok) regs_d[sel_addr] = sel_wdata;
        end else if (sel_b) begin
          b_rvalid_d = 1'b1;
          b_rdata_d  = rd_val;
        end else begin
          a_rvalid_d = 1'b1;
          a_rdata_d  = rd_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bank registers; reset aborts any access in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      cnt_q      <= 8'h00;
      a_rdata_q  <= 8'h00;
      b_rdata_q  <= 8'h00;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < REGCOUNT; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      addr_err_q <= addr_err_d;
      regs_q     <= regs_d;
    end
  end

  assign a_gnt          = (state_q == SERV_A);
  assign b_gnt          = (state_q == SERV_B);
  assign a_rvalid       = a_rvalid_q;
  assign b_rvalid       = b_rvalid_q;
  assign a_rdata        = a_rdata_q;
  assign b_rdata        = b_rdata_q;
  assign addr_err       = addr_err_q;
  assign contention_cnt = cnt_q;

  // Flatten the bank so register i sits on bits [8i+7:8i]
  for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
    assign registers_packed[8*g +: 8] = regs_q[g];
  end

endmodule
